// File: rtl/line_clear_ctrl_pkg.sv
// Shared board geometry, row type and line-clear sequencer state encoding.
package line_clear_ctrl_pkg;

    localparam int BOARD_WIDTH  = 10;
    localparam int BOARD_HEIGHT = 30;
    localparam int CELL_BITS    = 3;
    localparam int ROW_BITS     = BOARD_WIDTH * CELL_BITS;
    localparam int ROW_ADDR_W   = 5;

    typedef logic [ROW_BITS-1:0] row_t;

    localparam row_t EMPTY_ROW = {ROW_BITS{1'b0}};
    localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(BOARD_HEIGHT - 1);

    typedef enum logic [2:0] {
        LC_IDLE = 3'd0,
        LC_READ = 3'd1,
        LC_EVAL = 3'd2,
        LC_FILL = 3'd3,
        LC_DONE = 3'd4
    } lc_state_t;

endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// Flags a board row whose every cell is occupied (nonzero).
module row_full_detect
    import line_clear_ctrl_pkg::*;
(
    input  logic [ROW_BITS-1:0] row,
    output logic                full
);

    // AND-reduce the per-cell occupancy flags
    always_comb begin
        full = 1'b1;
        for (int j = 0; j < BOARD_WIDTH; j++) begin
            full = full & (|row[j*CELL_BITS +: CELL_BITS]);
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Post-lock line clear: scans bottom-to-top, compacts surviving rows down in place,
// then blanks the vacated top rows and reports how many lines were removed.
module line_clear_ctrl
    import line_clear_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            lines_cleared,
    output logic                  rd_en,
    output logic [4:0]            rd_row,
    input  logic [ROW_BITS-1:0]   rd_data,
    output logic                  wr_en,
    output logic [4:0]            wr_row,
    output logic [ROW_BITS-1:0]   wr_data
);

    lc_state_t          state_r, state_nx;
    logic [4:0]         src_r, src_nx;
    logic signed [5:0]  dst_r, dst_nx;
    logic [4:0]         cnt_r, cnt_nx;
    logic [4:0]         fill_r, fill_nx;

    logic               busy_r;
    logic               done_r;
    logic [4:0]         lines_cleared_r;
    logic               rd_en_r;
    logic [4:0]         rd_row_r;

    logic               row_full_s;
    logic               wr_en_s;
    logic [4:0]         wr_row_s;
    row_t               wr_data_s;

    row_full_detect u_row_full_detect (
        .row  (rd_data),
        .full (row_full_s)
    );

    // Next-state, pointer updates and the write port (EVAL writes depend on rd_data)
    always_comb begin
        state_nx  = state_r;
        src_nx    = src_r;
        dst_nx    = dst_r;
        cnt_nx    = cnt_r;
        fill_nx   = fill_r;
        wr_en_s   = 1'b0;
        wr_row_s  = 5'd0;
        wr_data_s = EMPTY_ROW;
        case (state_r)
            LC_IDLE: begin
                if (start) begin
                    src_nx   = LAST_ROW;
                    dst_nx   = $signed({1'b0, LAST_ROW});
                    cnt_nx   = 5'd0;
                    state_nx = LC_READ;
                end else begin
                    state_nx = LC_IDLE;
                end
            end
            LC_READ: begin
                state_nx = LC_EVAL;
            end
            LC_EVAL: begin
                if (row_full_s) begin
                    cnt_nx = cnt_r + 5'd1;
                end else begin
                    dst_nx = dst_r - 6'sd1;
                    // Once a full row has been skipped, survivors land below their source
                    if (dst_r != $signed({1'b0, src_r})) begin
                        wr_en_s   = 1'b1;
                        wr_row_s  = dst_r[4:0];
                        wr_data_s = rd_data;
                    end else begin
                        wr_en_s   = 1'b0;
                    end
                end
                if (src_r == 5'd0) begin
                    fill_nx  = 5'd0;
                    state_nx = (cnt_nx != 5'd0) ? LC_FILL : LC_DONE;
                end else begin
                    src_nx   = src_r - 5'd1;
                    state_nx = LC_READ;
                end
            end
            LC_FILL: begin
                wr_en_s   = 1'b1;
                wr_row_s  = fill_r;
                wr_data_s = EMPTY_ROW;
                fill_nx   = fill_r + 5'd1;
                if (fill_r == cnt_r - 5'd1) begin
                    state_nx = LC_DONE;
                end else begin
                    state_nx = LC_FILL;
                end
            end
            LC_DONE: begin
                state_nx = LC_IDLE;
            end
            default: begin
                state_nx = LC_IDLE;
            end
        endcase
    end

    // State, pointers and registered status/read outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= LC_IDLE;
            src_r           <= 5'd0;
            dst_r           <= 6'sd0;
            cnt_r           <= 5'd0;
            fill_r          <= 5'd0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            lines_cleared_r <= 5'd0;
            rd_en_r         <= 1'b0;
            rd_row_r        <= 5'd0;
        end else begin
            state_r  <= state_nx;
            src_r    <= src_nx;
            dst_r    <= dst_nx;
            cnt_r    <= cnt_nx;
            fill_r   <= fill_nx;
            busy_r   <= (state_nx != LC_IDLE);
            done_r   <= (state_nx == LC_DONE);
            rd_en_r  <= (state_nx == LC_READ);
            rd_row_r <= (state_nx == LC_READ) ? src_nx : rd_row_r;
            lines_cleared_r <= (state_nx == LC_DONE) ? cnt_nx : lines_cleared_r;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign lines_cleared = lines_cleared_r;
    assign rd_en         = rd_en_r;
    assign rd_row        = rd_row_r;
    assign wr_en         = wr_en_s;
    assign wr_row        = wr_row_s;
    assign wr_data       = wr_data_s;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl with a behavioural board RAM and a reference compaction model.
module tb_line_clear_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rd_en, wr_en;
    logic [4:0]  lines_cleared, rd_row, wr_row;
    logic [29:0] rd_data = 30'd0;
    logic [29:0] wr_data;

    logic [29:0] board [30];
    logic [29:0] init_board [30];
    logic        load = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] fm;
        logic [29:0] pm;
        int          lines;
    } vec_t;

    typedef struct {
        int                lines;
        int                cyc;
        int                writes;
        logic [29:0][29:0] brd;
    } exp_t;

    vec_t vecs [6];
    exp_t sbq [$];

    line_clear_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .rd_en         (rd_en),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data)
    );

    always #5 clk = ~clk;

    // Board RAM: registered read, one write per cycle, bulk load from init_board
    always @(posedge clk) begin
        if (load) begin
            for (int r = 0; r < 30; r++) board[r] <= init_board[r];
        end else begin
            if (rd_en) rd_data <= board[rd_row];
            if (wr_en) board[wr_row] <= wr_data;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [29:0] full_row(input int r);
        logic [29:0] v;
        for (int j = 0; j < 10; j++) v[j*3 +: 3] = 3'((r + j) % 7 + 1);
        return v;
    endfunction

    function automatic logic [29:0] partial_row(input int r);
        logic [29:0] v;
        v[2:0] = 3'd0;
        for (int j = 1; j < 10; j++) v[j*3 +: 3] = 3'((r * 3 + j) % 8);
        return v;
    endfunction

    function automatic logic is_full(input logic [29:0] v);
        for (int j = 0; j < 10; j++) begin
            if (v[j*3 +: 3] == 3'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic load_board(input logic [29:0] fm, input logic [29:0] pm);
        for (int r = 0; r < 30; r++) begin
            init_board[r] = fm[r] ? full_row(r) : (pm[r] ? partial_row(r) : 30'd0);
        end
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    // Reference: gather surviving rows bottom-first and restack them from the floor
    task automatic make_expected(input int lines_tab, output exp_t e);
        int ns = 0;
        int maxfull = -1;
        int above = 0;
        e.brd = '0;
        for (int r = 29; r >= 0; r--) begin
            if (is_full(init_board[r])) begin
                if (maxfull < 0) maxfull = r;
            end else begin
                e.brd[29 - ns] = init_board[r];
                ns++;
            end
        end
        for (int r = 0; r < 30; r++) begin
            if (!is_full(init_board[r]) && r < maxfull) above++;
        end
        e.lines  = lines_tab;
        e.cyc    = 61 + lines_tab;
        e.writes = above + (30 - ns);
    endtask

    task automatic run_pass(input int lines_tab, input int restart_at);
        exp_t e, got_e;
        int n = 1;
        int done_n = 0;
        int dones = 0;
        int wrs = 0;
        bit overlap = 1'b0;
        bit got = 1'b0;
        make_expected(lines_tab, e);
        sbq.push_back(e);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (n <= 200) begin
            if (rd_en && wr_en) overlap = 1'b1;
            if (wr_en) wrs++;
            start = (restart_at == n);
            if (done) begin
                dones++;
                if (!got) begin
                    got = 1'b1;
                    done_n = n;
                    got_e = sbq.pop_front();
                    chk("lines_cleared", lines_cleared, got_e.lines);
                    chk("done_cycle", done_n, got_e.cyc);
                end
            end
            if (got && n >= done_n + 4) break;
            @(posedge clk);
            #1 n++;
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none expected=%0d", e.cyc);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else begin
            chk("write_count", wrs, got_e.writes);
            chk("done_pulses", dones, 1);
            chk("rd_wr_overlap", overlap, 0);
            chk("idle_busy", busy, 0);
            chk("lines_hold", lines_cleared, got_e.lines);
            for (int r = 0; r < 30; r++) begin
                chk($sformatf("board_row%0d", r), board[r], got_e.brd[r]);
            end
        end
    endtask

    initial begin
        vecs[0] = '{fm: 30'h0000_0000, pm: 30'h0000_0000, lines: 0};
        vecs[1] = '{fm: 30'h2000_0000, pm: 30'h1000_0000, lines: 1};
        vecs[2] = '{fm: 30'h3C00_0000, pm: 30'h0200_0000, lines: 4};
        vecs[3] = '{fm: 30'h2800_0000, pm: 30'h1600_0000, lines: 2};
        vecs[4] = '{fm: 30'h3FFF_FFFF, pm: 30'h0000_0000, lines: 30};
        vecs[5] = '{fm: 30'h2000_0421, pm: 30'h0FF0_F0D0, lines: 4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_row", rd_row, 0);
        chk("rst_wr_row", wr_row, 0);
        chk("rst_wr_data", wr_data, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            load_board(vecs[i].fm, vecs[i].pm);
            run_pass(vecs[i].lines, 0);
        end

        // A second start mid-pass must be ignored
        load_board(vecs[1].fm, vecs[1].pm);
        run_pass(vecs[1].lines, 10);

        // Asynchronous reset in the middle of a pass
        load_board(vecs[3].fm, vecs[3].pm);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_done", done, 0);
        chk("midrst_lines", lines_cleared, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 chk("midrst_quiet", {rd_en, wr_en, busy}, 0);
        end
        @(negedge clk) rst_n = 1'b1;

        load_board(vecs[3].fm, vecs[3].pm);
        run_pass(vecs[3].lines, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
